mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Data-side memory access controller in the MEM stage; the producer of the `suspend` stall that the MEM/WB pipeline register consumes.
- Takes load/store requests from the EX/MEM register (valid, byte write enables, address, store data, load-extend op) and runs a req/gnt + rvalid handshake on the data bus.
- Holds `suspend` high until the access completes, then presents sign/zero-extended load data in `ram_ext_out` for MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ+RESP before the access is aborted with `bus_err`; must be ≥2.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- cpu_clk  in  1  clock, rising edge.
- cpu_rstn  in  1  reset, asynchronous, active-low.
- valid_in  in  1  MEM-stage instruction valid.
- mem_re_in  in  1  instruction is a load.
- ram_we_in  in  4  store byte-lane mask, already lane-aligned; nonzero means store.
- da_addr_in  in  32  byte address.
- da_wdata_in  in  32  store data, already lane-aligned.
- ram_ext_op_in  in  3  load extend op: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned, others treated as word.
- suspend  out  1  pipeline stall (combinational).
- ram_ext_out  out  32  extended load data (registered).
- bus_err  out  1  one-cycle pulse on timeout.
- bus_req  out  1  bus request.
- bus_we  out  4  bus byte write strobes; 0 means read.
- bus_addr  out  32  bus address, word-aligned ({addr[31:2],2'b00}).
- bus_wdata  out  32  bus write data.
- bus_gnt  in  1  slave accepts the request this cycle.
- bus_rvalid  in  1  response: read data valid, or write acknowledge.
- bus_rdata  in  32  read data word.

Behaviour:
- `access` = valid_in & (ram_we_in != 0 | mem_re_in). A store takes priority when ram_we_in != 0 and mem_re_in are both set.
- States: IDLE, REQ, RESP, DONE. All state and outputs are registered except `suspend`.
- IDLE:
  - If `access`, go to REQ.
  - On that transition, capture bus_addr (word-aligned), bus_we (ram_we_in for stores, 0 for loads), bus_wdata, addr[1:0] and ram_ext_op_in.
- REQ: bus_req = 1.
  - bus_gnt & bus_rvalid → DONE.
  - bus_gnt only → RESP.
  - Otherwise stay in REQ.
- RESP: bus_req = 0; bus_rvalid → DONE.
- DONE: one cycle, then IDLE unconditionally. No access is re-issued even though the same instruction is still presented at the inputs during DONE.
- Load capture: on the cycle bus_rvalid is sampled for a load, ram_ext_out <= extend(bus_rdata, captured op, captured addr[1:0]).
  - Byte lane = addr[1:0].
  - Half lane = addr[1]; addr[0] is ignored.
  - Signed ops replicate the MSB of the selected field; unsigned ops zero-fill.
- Stores leave ram_ext_out unchanged. ram_ext_out otherwise holds until the next load completes.
- suspend = (state==IDLE & access) | state==REQ | state==RESP. It is low in DONE, so the pipeline advances at the end of DONE.
- Timeout:
  - Counter clears on IDLE→REQ and increments every cycle in REQ or RESP.
  - When the count equals TIMEOUT_CYCLES-1 and no completion occurs that cycle, go to DONE, pulse bus_err for that DONE cycle and load ram_ext_out <= 0 (even for stores).
  - Completion in the same cycle as the limit wins; no bus_err.
- bus_we, bus_addr and bus_wdata hold the captured values through REQ/RESP/DONE and return to 0 in IDLE.
- Minimum latency from `access` to the pipeline advancing: 3 cycles (IDLE, REQ with gnt+rvalid, DONE).
- Reset (cpu_rstn low, asynchronous, may occur mid-transfer):
  - state = IDLE; bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, ram_ext_out = 0, bus_err = 0; counter = 0.
  - suspend then follows only the IDLE term.
  - An in-flight bus transaction is abandoned; a late bus_rvalid arriving in IDLE is ignored.
- bus_gnt or bus_rvalid arriving outside REQ/RESP is ignored.

Test Plan:
- LB signed: addr 0x1003, op 001, gnt in REQ cycle, rvalid next cycle with rdata 0x80FF_0000 → suspend high for 3 cycles, ram_ext_out = 0xFFFF_FF80, bus_addr = 0x1000.
- LHU with gnt+rvalid same cycle: addr 0x2002, op 100, rdata 0xBEEF_1234 → suspend high 2 cycles, ram_ext_out = 0x0000_BEEF, RESP skipped.
- SB: ram_we 4'b0100, wdata 0x00AA_0000 → bus_we = 0100, bus_wdata = 0x00AA_0000, ram_ext_out unchanged, suspend released in DONE.
- gnt delayed 5 cycles, rvalid 3 cycles after gnt → suspend high exactly 1+6+3+... until DONE; bus_req high only during REQ; bus_req stays high across the 5 stall cycles.
- Timeout with TIMEOUT_CYCLES=4, no gnt → bus_err pulses once on the 5th cycle after access, ram_ext_out = 0, state returns to IDLE.
- Reset asserted in RESP, then a late rvalid after release → bus_req = 0 immediately, ram_ext_out = 0, no capture from the late rvalid.
- valid_in = 0 with ram_we = 4'hF → no bus_req, suspend stays 0.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//
// Data-side memory access controller for the MEM stage. Takes a load or store
// from the EX/MEM register, runs it on the data bus and stalls the pipeline
// (suspend) until the access finishes. Load data is extended to 32 bits and
// presented in ram_ext_out for the MEM/WB register.
//
// Bus handshake: the controller holds bus_req high, with bus_we/bus_addr/
// bus_wdata stable, until it samples bus_gnt high on a rising edge; that edge
// transfers the request. bus_rvalid then marks the single response beat (read
// data for loads, acknowledge for stores). It may arrive in the same cycle as
// bus_gnt or in any later cycle. bus_gnt and bus_rvalid are ignored outside
// the REQ and RESP states.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed in REQ+RESP before aborting (>= 2)
//   CNT_W           timeout counter width (2**CNT_W > TIMEOUT_CYCLES)
//
// Ports:
//   cpu_clk, cpu_rstn           clock (rising edge), async active-low reset
//   valid_in, mem_re_in         MEM-stage instruction valid, is-load
//   ram_we_in[3:0]              store byte lanes (nonzero = store)
//   da_addr_in[31:0]            byte address
//   da_wdata_in[31:0]           lane-aligned store data
//   ram_ext_op_in[2:0]          load extend op
//   suspend                     pipeline stall (combinational)
//   ram_ext_out[31:0]           extended load data (registered)
//   bus_err                     one-cycle pulse on timeout
//   bus_req, bus_we, bus_addr,
//   bus_wdata                   bus request side
//   bus_gnt, bus_rvalid,
//   bus_rdata                   bus slave side
//   dbg_state[1:0]              current FSM state (0 IDLE,1 REQ,2 RESP,3 DONE)
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        valid_in,
    input  logic        mem_re_in,
    input  logic [3:0]  ram_we_in,
    input  logic [31:0] da_addr_in,
    input  logic [31:0] da_wdata_in,
    input  logic [2:0]  ram_ext_op_in,
    output logic        suspend,
    output logic [31:0] ram_ext_out,
    output logic        bus_err,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic [1:0]       lane_q;
    logic [2:0]       ext_op_q;

    logic access;
    logic in_flight;
    logic complete;
    logic timeout_hit;
    logic is_load_q;

    // Extract and extend the addressed field of a read word.
    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [2:0]  op,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        // Halfword lane uses addr[1] only; addr[0] is ignored.
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            3'b001:  r = {{24{b[7]}}, b};
            3'b010:  r = {24'd0, b};
            3'b011:  r = {{16{h[15]}}, h};
            3'b100:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign access    = valid_in & ((ram_we_in != 4'd0) | mem_re_in);
    assign in_flight = (state == S_REQ) | (state == S_RESP);
    // bus_we was captured as zero for loads, so it doubles as the load flag.
    assign is_load_q = (bus_we == 4'd0);

    assign complete = ((state == S_REQ)  & bus_gnt & bus_rvalid) |
                      ((state == S_RESP) & bus_rvalid);

    // A completion on the limit cycle takes precedence over the abort.
    assign timeout_hit = in_flight & (to_cnt == TO_LIMIT) & ~complete;

    assign dbg_state = state;

    // Next state and the combinational stall.
    always_comb begin
        state_nxt = state;
        suspend   = 1'b0;
        case (state)
            S_IDLE: begin
                suspend = access;
                if (access) state_nxt = S_REQ;
            end
            S_REQ: begin
                suspend = 1'b1;
                if (complete || timeout_hit) state_nxt = S_DONE;
                else if (bus_gnt)            state_nxt = S_RESP;
            end
            S_RESP: begin
                suspend = 1'b1;
                if (complete || timeout_hit) state_nxt = S_DONE;
            end
            // DONE always returns to IDLE; the instruction still sitting at
            // the inputs is the one just finished, so it must not re-issue.
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout counter: cleared on entry to REQ, counts REQ+RESP cycles.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            to_cnt <= '0;
        end else if ((state == S_IDLE) && access) begin
            to_cnt <= '0;
        end else if (in_flight) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Registered request side of the bus.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            bus_req   <= 1'b0;
            bus_we    <= 4'd0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            lane_q    <= 2'd0;
            ext_op_q  <= 3'd0;
        end else begin
            bus_req <= (state_nxt == S_REQ);
            if ((state == S_IDLE) && access) begin
                bus_addr  <= {da_addr_in[31:2], 2'b00};
                // A nonzero byte mask wins over mem_re_in.
                bus_we    <= (ram_we_in != 4'd0) ? ram_we_in : 4'd0;
                bus_wdata <= da_wdata_in;
                lane_q    <= da_addr_in[1:0];
                ext_op_q  <= ram_ext_op_in;
            end else if (state == S_DONE) begin
                bus_we    <= 4'd0;
                bus_addr  <= 32'd0;
                bus_wdata <= 32'd0;
            end
        end
    end

    // Load result and error pulse.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            ram_ext_out <= 32'd0;
            bus_err     <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (timeout_hit) begin
                ram_ext_out <= 32'd0;
            end else if (complete && is_load_q) begin
                ram_ext_out <= load_extend(bus_rdata, ext_op_q, lane_q);
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
//
// Directed bench for mem_bus_ctrl. Two instances share all inputs: "dut" with
// the default timeout and "dut_to" with TIMEOUT_CYCLES=4 for the abort path.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic        mem_re_in = 1'b0;
  logic [3:0]  ram_we_in = 4'd0;
  logic [31:0] da_addr_in = 32'd0;
  logic [31:0] da_wdata_in = 32'd0;
  logic [2:0]  ram_ext_op_in = 3'd0;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  logic        suspend, bus_err, bus_req;
  logic [31:0] ram_ext_out, bus_addr, bus_wdata;
  logic [3:0]  bus_we;
  logic [1:0]  dbg_state;

  logic        suspend_t, bus_err_t, bus_req_t;
  logic [31:0] ram_ext_out_t, bus_addr_t, bus_wdata_t;
  logic [3:0]  bus_we_t;
  logic [1:0]  dbg_state_t;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 cpu_clk = ~cpu_clk;

  mem_bus_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .valid_in(valid_in),
    .mem_re_in(mem_re_in), .ram_we_in(ram_we_in), .da_addr_in(da_addr_in),
    .da_wdata_in(da_wdata_in), .ram_ext_op_in(ram_ext_op_in),
    .suspend(suspend), .ram_ext_out(ram_ext_out), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut_to (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .valid_in(valid_in),
    .mem_re_in(mem_re_in), .ram_we_in(ram_we_in), .da_addr_in(da_addr_in),
    .da_wdata_in(da_wdata_in), .ram_ext_op_in(ram_ext_op_in),
    .suspend(suspend_t), .ram_ext_out(ram_ext_out_t), .bus_err(bus_err_t),
    .bus_req(bus_req_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
    .bus_wdata(bus_wdata_t), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .dbg_state(dbg_state_t)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    valid_in = 1'b0; mem_re_in = 1'b0; ram_we_in = 4'd0;
    da_addr_in = 32'd0; da_wdata_in = 32'd0; ram_ext_op_in = 3'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
  endtask

  task automatic do_reset();
    cpu_rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge cpu_clk);
    #1 cpu_rstn = 1'b1;
  endtask

  // Present one instruction and answer it: gnt gd cycles into REQ, rvalid
  // rd cycles after gnt (0 = same cycle). Returns at the falling edge of the
  // first cycle where suspend is low (DONE), instruction still applied.
  task automatic run_access(input logic [3:0] we, input logic re,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] op, input logic [31:0] rdata,
                            input int gd, input int rd,
                            output int susp_n, output int req_n,
                            output logic [31:0] a_seen, output logic [3:0] we_seen,
                            output logic [31:0] wd_seen, output logic resp_seen);
    logic done;
    done = 1'b0;
    susp_n = 0; req_n = 0; resp_seen = 1'b0;
    a_seen = 32'd0; we_seen = 4'd0; wd_seen = 32'd0;
    valid_in = 1'b1; mem_re_in = re; ram_we_in = we;
    da_addr_in = addr; da_wdata_in = wdata; ram_ext_op_in = op;
    for (int k = 0; k < 60; k++) begin
      bus_gnt    = (k == 1 + gd);
      bus_rvalid = (k == 1 + gd + rd);
      bus_rdata  = bus_rvalid ? rdata : 32'hDEAD_BEEF;
      @(negedge cpu_clk);
      if (!suspend) begin
        done = 1'b1;
        break;
      end
      susp_n++;
      if (bus_req) req_n++;
      if (dbg_state == 2'd2) resp_seen = 1'b1;
      if (k == 1 + gd) begin
        a_seen = bus_addr; we_seen = bus_we; wd_seen = bus_wdata;
      end
      @(posedge cpu_clk); #1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    if (!done) check("access_bound", 32'd0, 32'd1);
  endtask

  // Leave DONE, retire the instruction and confirm the bus went idle.
  task automatic end_access(input string tag);
    @(posedge cpu_clk); #1;
    valid_in = 1'b0; mem_re_in = 1'b0; ram_we_in = 4'd0;
    @(negedge cpu_clk);
    check({tag, "_idle_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_idle_addr"},  bus_addr, 32'd0);
    check({tag, "_idle_we"},    32'(bus_we), 32'd0);
    check({tag, "_idle_susp"},  32'(suspend), 32'd0);
    @(posedge cpu_clk); #1;
  endtask

  // Access on the TIMEOUT_CYCLES=4 instance; hit=1 completes on the last
  // allowed REQ cycle, hit=0 never grants and must abort.
  task automatic run_to(input string tag, input logic hit, input logic [31:0] rdata);
    valid_in = 1'b1; mem_re_in = 1'b1; ram_we_in = 4'd0;
    da_addr_in = 32'h0000_A000; ram_ext_op_in = 3'd0;
    for (int k = 0; k <= 5; k++) begin
      bus_gnt    = hit && (k == 4);
      bus_rvalid = hit && (k == 4);
      bus_rdata  = rdata;
      @(negedge cpu_clk);
      check($sformatf("%s_req%0d", tag, k), 32'(bus_req_t), 32'((k >= 1) && (k <= 4)));
      check($sformatf("%s_susp%0d", tag, k), 32'(suspend_t), 32'(k < 5));
      if (k == 5) begin
        check({tag, "_err"},   32'(bus_err_t), 32'(!hit));
        check({tag, "_data"},  ram_ext_out_t, hit ? rdata : 32'd0);
        check({tag, "_state"}, 32'(dbg_state_t), 32'd3);
      end else begin
        check($sformatf("%s_noerr%0d", tag, k), 32'(bus_err_t), 32'd0);
      end
      @(posedge cpu_clk); #1;
    end
    clear_inputs();
    @(negedge cpu_clk);
    check({tag, "_after_state"}, 32'(dbg_state_t), 32'd0);
    check({tag, "_after_err"},   32'(bus_err_t), 32'd0);
    check({tag, "_after_susp"},  32'(suspend_t), 32'd0);
    @(posedge cpu_clk); #1;
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int          sn, rn;
    logic [31:0] as, ws;
    logic [3:0]  wes;
    logic        rs;

    do_reset();

    // Reset state
    @(negedge cpu_clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_req",   32'(bus_req), 32'd0);
    check("rst_data",  ram_ext_out, 32'd0);
    check("rst_addr",  bus_addr, 32'd0);
    check("rst_err",   32'(bus_err), 32'd0);
    check("rst_susp",  32'(suspend), 32'd0);
    @(posedge cpu_clk); #1;

    // LB signed, lane 3, gnt then rvalid next cycle
    run_access(4'd0, 1'b1, 32'h0000_1003, 32'd0, 3'b001, 32'h80FF_0000, 0, 1,
               sn, rn, as, wes, ws, rs);
    check("lb_susp_cycles", 32'(sn), 32'd3);
    check("lb_req_cycles",  32'(rn), 32'd1);
    check("lb_addr",        as, 32'h0000_1000);
    check("lb_we",          32'(wes), 32'd0);
    check("lb_resp_seen",   32'(rs), 32'd1);
    check("lb_data",        ram_ext_out, 32'hFFFF_FF80);
    check("lb_done_req",    32'(bus_req), 32'd0);
    check("lb_done_err",    32'(bus_err), 32'd0);
    end_access("lb");

    // LHU with gnt+rvalid together, upper half
    run_access(4'd0, 1'b1, 32'h0000_2002, 32'd0, 3'b100, 32'hBEEF_1234, 0, 0,
               sn, rn, as, wes, ws, rs);
    check("lhu_susp_cycles", 32'(sn), 32'd2);
    check("lhu_resp_skip",   32'(rs), 32'd0);
    check("lhu_data",        ram_ext_out, 32'h0000_BEEF);
    end_access("lhu");

    // SB lane 2: load data must not change
    run_access(4'b0100, 1'b0, 32'h0000_3002, 32'h00AA_0000, 3'b000, 32'hFFFF_FFFF, 0, 1,
               sn, rn, as, wes, ws, rs);
    check("sb_susp_cycles", 32'(sn), 32'd3);
    check("sb_we",          32'(wes), 32'b0100);
    check("sb_wdata",       ws, 32'h00AA_0000);
    check("sb_addr",        as, 32'h0000_3000);
    check("sb_data_hold",   ram_ext_out, 32'h0000_BEEF);
    end_access("sb");

    // Store mask and mem_re both set: treated as a store
    run_access(4'b0001, 1'b1, 32'h0000_3000, 32'h0000_0055, 3'b000, 32'h1234_5678, 0, 0,
               sn, rn, as, wes, ws, rs);
    check("prio_we",   32'(wes), 32'b0001);
    check("prio_data", ram_ext_out, 32'h0000_BEEF);
    end_access("prio");

    // LW with gnt delayed 5 cycles, rvalid 3 cycles after gnt
    run_access(4'd0, 1'b1, 32'h0000_4000, 32'd0, 3'b000, 32'hCAFE_F00D, 5, 3,
               sn, rn, as, wes, ws, rs);
    check("slow_susp_cycles", 32'(sn), 32'd10);
    check("slow_req_cycles",  32'(rn), 32'd6);
    check("slow_data",        ram_ext_out, 32'hCAFE_F00D);
    end_access("slow");

    // LH signed, addr[0] ignored
    run_access(4'd0, 1'b1, 32'h0000_5001, 32'd0, 3'b011, 32'h1234_8001, 0, 0,
               sn, rn, as, wes, ws, rs);
    check("lh_data", ram_ext_out, 32'hFFFF_8001);
    end_access("lh");

    // LBU lane 2
    run_access(4'd0, 1'b1, 32'h0000_6002, 32'd0, 3'b010, 32'h00AB_0000, 0, 0,
               sn, rn, as, wes, ws, rs);
    check("lbu_data", ram_ext_out, 32'h0000_00AB);
    end_access("lbu");

    // Undefined op behaves as word
    run_access(4'd0, 1'b1, 32'h0000_7001, 32'd0, 3'b111, 32'h1357_9BDF, 1, 0,
               sn, rn, as, wes, ws, rs);
    check("opx_susp_cycles", 32'(sn), 32'd3);
    check("opx_data",        ram_ext_out, 32'h1357_9BDF);
    end_access("opx");

    // valid_in low: no access; stray gnt/rvalid ignored
    valid_in = 1'b0; ram_we_in = 4'hF; mem_re_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus_gnt = k[0]; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
      @(negedge cpu_clk);
      check($sformatf("novalid_req%0d", k),  32'(bus_req), 32'd0);
      check($sformatf("novalid_susp%0d", k), 32'(suspend), 32'd0);
      @(posedge cpu_clk); #1;
    end
    clear_inputs();
    @(negedge cpu_clk);
    check("novalid_state", 32'(dbg_state), 32'd0);
    check("novalid_data",  ram_ext_out, 32'h1357_9BDF);
    @(posedge cpu_clk); #1;

    // Reset during RESP, late rvalid afterwards
    valid_in = 1'b1; mem_re_in = 1'b1; da_addr_in = 32'h0000_8000; ram_ext_op_in = 3'b000;
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b1;
    @(negedge cpu_clk);
    check("rr_req_in_req", 32'(bus_req), 32'd1);
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b0;
    @(negedge cpu_clk);
    check("rr_in_resp", 32'(dbg_state), 32'd2);
    check("rr_addr",    bus_addr, 32'h0000_8000);
    #1 cpu_rstn = 1'b0;
    #1;
    check("rr_state",     32'(dbg_state), 32'd0);
    check("rr_data",      ram_ext_out, 32'd0);
    check("rr_addr_clr",  bus_addr, 32'd0);
    check("rr_req",       32'(bus_req), 32'd0);
    check("rr_susp_idle", 32'(suspend), 32'd1);
    valid_in = 1'b0; mem_re_in = 1'b0;
    #1;
    check("rr_susp_off", 32'(suspend), 32'd0);
    @(posedge cpu_clk); #1 cpu_rstn = 1'b1;
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b0;
    @(negedge cpu_clk);
    check("rr_late_data",  ram_ext_out, 32'd0);
    check("rr_late_state", 32'(dbg_state), 32'd0);
    check("rr_late_req",   32'(bus_req), 32'd0);
    @(posedge cpu_clk); #1;

    // Timeout instance: prime its load data, then abort and limit-hit cases
    run_access(4'd0, 1'b1, 32'h0000_9000, 32'd0, 3'b000, 32'h0F0F_0F0F, 0, 1,
               sn, rn, as, wes, ws, rs);
    check("to_prime_data", ram_ext_out_t, 32'h0F0F_0F0F);
    end_access("to_prime");
    run_to("to_abort", 1'b0, 32'hFFFF_FFFF);
    do_reset();
    run_to("to_limit", 1'b1, 32'h600D_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
